// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type, the data-word width, the wait-counter width and
// a helper that derives the word-index width from the memory depth.
package data_mem_responder_pkg;

    localparam int unsigned WORD_W              = 32;
    localparam int unsigned LAT_CNT_W           = 4;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmr_state_e;

    // Word-index width for a given depth; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth_words);
        return (depth_words <= 1) ? 1 : $clog2(depth_words);
    endfunction

    localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_DEPTH_WORDS);

endpackage

// File: rtl/dmr_storage.sv
// Word array behind the data-memory responder.
// Synchronous write, registered read, whole array cleared on reset.
// Ports:
//   clk_i, rst_i   clock (rising edge) and asynchronous active-low reset
//   wr_en_i        write wdata_i into word idx_i at this edge
//   rd_en_i        load the read register at this edge
//   rd_kill_i      with rd_en_i: load zero instead of the addressed word
//   idx_i          word index
//   wdata_i        write data
//   rdata_o        registered read data
module dmr_storage
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = DEFAULT_IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              rd_kill_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Array and read register; stores and rejected accesses read back as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            if (rd_en_i) begin
                rdata_q <= rd_kill_i ? '0 : mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the CPU memory stage.
// Accepts one load/store on a valid/ready request channel, waits LATENCY
// cycles, performs the word access and presents the result on a valid/ready
// response channel until the CPU takes it.
// Ports:
//   clk_i, rst_i                clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o   request handshake
//   req_we_i                    1 = store, 0 = load
//   req_addr_i, req_wdata_i     byte address and store data
//   resp_valid_o / resp_ready_i response handshake
//   resp_rdata_o                load data (0 for stores and errors)
//   resp_err_o                  address out of range (or misaligned if trapping)
// Build option: define MISALIGN_TRAP_EN to reject addresses with addr[1:0] != 0;
// otherwise the low two address bits are ignored.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [WORD_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [WORD_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] RANGE_BYTES = WORD_W'(4 * DEPTH_WORDS);
    localparam logic [LAT_CNT_W-1:0] LAT_INIT =
        LAT_CNT_W'((LATENCY == 0) ? 0 : (LATENCY - 1));

    dmr_state_e        state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              acc_fire_c;
    logic              acc_we_c;
    logic              acc_bad_c;
    logic [WORD_W-1:0] acc_addr_c;
    logic [WORD_W-1:0] acc_wdata_c;
    logic [IDX_W-1:0]  acc_idx_c;

    // An access is rejected when it falls outside the array (or is misaligned when trapping).
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr);
        logic bad;
        bad = (addr >= RANGE_BYTES);
`ifdef MISALIGN_TRAP_EN
        bad = bad | (addr[1:0] != 2'b00);
`endif
        return bad;
    endfunction

    // Next-state logic; the access uses live inputs only when LATENCY is zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        err_d       = err_q;
        acc_fire_c  = 1'b0;
        acc_we_c    = we_q;
        acc_addr_c  = addr_q;
        acc_wdata_c = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        acc_fire_c  = 1'b1;
                        acc_we_c    = req_we_i;
                        acc_addr_c  = req_addr_i;
                        acc_wdata_c = req_wdata_i;
                        state_d     = ST_RESP;
                        valid_d     = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire_c = 1'b1;
                    state_d    = ST_RESP;
                    valid_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        acc_bad_c = addr_bad(acc_addr_c);
        if (acc_fire_c) begin
            err_d = acc_bad_c;
        end
    end

    // State, captured request and response flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign acc_idx_c = acc_addr_c[IDX_W+1:2];

    dmr_storage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_storage (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (acc_fire_c & acc_we_c & ~acc_bad_c),
        .rd_en_i   (acc_fire_c),
        .rd_kill_i (acc_we_c | acc_bad_c),
        .idx_i     (acc_idx_c),
        .wdata_i   (acc_wdata_c),
        .rdata_o   (resp_rdata_o)
    );

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance driven by a vector table,
// random traffic against a reference memory and a mid-operation reset, plus a
// LATENCY=0 instance for the zero-wait path.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned LAT   = 2;
`ifdef MISALIGN_TRAP_EN
    localparam logic MIS_TRAP = 1'b1;
`else
    localparam logic MIS_TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(z_req_we),
        .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata),
        .resp_valid_o(z_resp_valid), .resp_ready_i(z_resp_ready),
        .resp_rdata_o(z_resp_rdata), .resp_err_o(z_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory: word array, out-of-range (and optionally misaligned) rejected.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        logic [31:0] word;
        err = (addr >= 32'(4 * DEPTH));
        if (MIS_TRAP && (addr[1:0] != 2'b00)) err = 1'b1;
        word  = addr >> 2;
        rdata = 32'h0;
        if (!err) begin
            if (we) ref_mem[word[6:0]] = wdata;
            else    rdata = ref_mem[word[6:0]];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
    endfunction

    // One full transaction on the LATENCY=2 instance; called from a negedge in IDLE.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input logic [31:0] exp_rdata, input logic exp_err,
                        input string tag);
        int          lat;
        logic        busy_ok, stable;
        logic [31:0] held;
        chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Garbage while busy must neither be accepted nor disturb the captured request.
        req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = -1; busy_ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (req_ready) busy_ok = 1'b0;
        end
        req_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        chk({tag, " busy ready low"}, 32'(busy_ok), 32'd1);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
        held = resp_rdata; stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_rdata !== held || resp_err !== exp_err)
                stable = 1'b0;
        end
        if (stall > 0) chk({tag, " stall hold"}, 32'(stable), 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " resp dropped"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    // One transaction on the LATENCY=0 instance.
    task automatic z_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata;
        @(posedge clk); #1;
        z_req_valid = 1'b0; z_req_addr = $urandom; z_req_wdata = $urandom;
        @(negedge clk);
        chk({tag, " valid next cycle"}, 32'(z_resp_valid), 32'd1);
        chk({tag, " ready low"}, 32'(z_req_ready), 32'd0);
        chk({tag, " rdata"}, z_resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(z_resp_err), 32'(exp_err));
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " resp dropped"}, 32'(z_resp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, addr, wd;
        logic        er, we;
        int          r;

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
        model_reset();

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0,   32'h11111111, 0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h200, 32'hAAAA5555, 1, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        0, 32'h11111111, 1'b0});
        vecs.push_back('{1'b0, 32'h200, 32'h0,        0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h10,  32'h12345678, 0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h13,  32'h0,        2,
                         MIS_TRAP ? 32'h0 : 32'h12345678, MIS_TRAP});
        vecs.push_back('{1'b1, 32'h1FC, 32'hCAFEF00D, 0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h1FC, 32'h0,        0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h1FE, 32'h55AA55AA, 0, 32'h0,        MIS_TRAP});
        vecs.push_back('{1'b0, 32'h1FC, 32'h0,        0,
                         MIS_TRAP ? 32'hCAFEF00D : 32'h55AA55AA, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset rdata", resp_rdata, 32'h0);
        chk("reset err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait instance.
        z_xact(1'b0, 32'h0,   32'h0,        32'h0,        1'b0, "z load0");
        z_xact(1'b1, 32'h8,   32'h0BADF00D, 32'h0,        1'b0, "z store8");
        z_xact(1'b0, 32'h8,   32'h0,        32'h0BADF00D, 1'b0, "z load8");
        z_xact(1'b0, 32'h400, 32'h0,        32'h0,        1'b1, "z load oob");

        // Directed vector table.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
                 vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Random traffic against the reference memory.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      addr = 32'($urandom_range(0, 15)) << 2;
            else if (r < 7) addr = 32'($urandom_range(0, 127)) << 2;
            else if (r < 8) addr = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
            else            addr = 32'h200 + 32'($urandom_range(0, 4095));
            we = 1'($urandom);
            wd = $urandom;
            model(we, addr, wd, rd, er);
            xact(we, addr, wd, int'($urandom_range(0, 3)), rd, er, $sformatf("rnd%0d", n));
        end

        // Reset while a store sits in WAIT: it must never land.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h77777777;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst in wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst rdata", resp_rdata, 32'h0);
        chk("midrst err", 32'(resp_err), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model(1'b0, 32'h20, 32'h0, rd, er);
        xact(1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0, "after midrst load20");
        model(1'b0, 32'h10, 32'h0, rd, er);
        xact(1'b0, 32'h10, 32'h0, 0, rd, er, "after midrst load10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
